// File: rtl/if_unit_pkg.sv
// Shared definitions for the instruction fetch unit: jump-mode encodings,
// FSM state codes and the NOP opcode/argument driven while the core is idle.
package if_unit_pkg;

  typedef enum logic [1:0] {
    JMP_ABS  = 2'b00,
    JMP_BASE = 2'b01,
    JMP_RET  = 2'b10,
    JMP_HOLD = 2'b11
  } jmp_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] NOP_OP  = 8'h00;
  localparam logic [7:0] NOP_ARG = 8'h00;

endpackage

// File: rtl/if_link_stack.sv
// Return-address storage for CALL/RET.
// IF_LR_STACK_EN defined: LR_DEPTH-entry circular stack; a push when full
// overwrites the oldest entry, and both overflow and underflow set err_o.
// IF_LR_STACK_EN undefined: one link register; a push overwrites it and a
// return always uses it; err_o only flags a return before any push.
// Pop has priority if push and pop arrive in the same cycle.
module if_link_stack #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] push_data_i,
  output logic [AW-1:0] pop_data_o,
  output logic          empty_o,
  output logic          err_o
);

`ifdef IF_LR_STACK_EN
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] stk_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] top_ptr;
  logic [PW:0]   count_q;
  logic          full;
  logic          err_q;

  assign top_ptr    = wr_ptr_q - PW'(1);
  assign full       = (count_q == (PW+1)'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign pop_data_o = stk_q[top_ptr];
  assign err_o      = err_q;

  // Circular stack: write pointer marks the next free slot, count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else if (pop_i) begin
      if (empty_o) begin
        err_q <= 1'b1;
      end else begin
        wr_ptr_q <= top_ptr;
        count_q  <= count_q - (PW+1)'(1);
      end
    end else if (push_i) begin
      stk_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q        <= wr_ptr_q + PW'(1);
      if (full) err_q <= 1'b1;
      else      count_q <= count_q + (PW+1)'(1);
    end
  end
`else
  logic [AW-1:0] lr_q;
  logic          valid_q;
  logic          err_q;

  assign pop_data_o = lr_q;
  assign empty_o    = !valid_q;
  assign err_o      = err_q;

  // Single link register; valid_q remembers whether anything was ever pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lr_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (pop_i) begin
      if (!valid_q) err_q <= 1'b1;
    end else if (push_i) begin
      lr_q    <= push_data_i;
      valid_q <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/if_unit.sv
// Instruction fetch unit: program memory, PC, base register and link storage.
// Fetch is combinational from the PC; all state changes on the rising edge.
// Optional macro IF_LR_STACK_EN selects a multi-entry link stack.
// Program loading is accepted only while IDLE; load_ack_o pulses one cycle later.
module if_unit
  import if_unit_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LR_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  load_en_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic [2*WIDTH-1:0]    load_data_i,
  output logic                  load_ack_o,
  input  logic                  pc_rst_i,
  input  logic                  pc_ld_i,
  input  logic [1:0]            jmp_mode_i,
  input  logic [WIDTH-1:0]      jmp_target_i,
  input  logic                  base_reg_ld_i,
  input  logic [WIDTH-1:0]      base_reg_data_i,
  input  logic [WIDTH-1:0]      base_reg_offset_i,
  input  logic                  lr_ld_i,
  output logic [WIDTH-1:0]      instr_o,
  output logic [WIDTH-1:0]      arg_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  running_o,
  output logic                  lr_err_o,
  output state_t                state_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [2*WIDTH-1:0]    mem_q [DEPTH];
  state_t                state_q;
  logic                  load_ack_q;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic [WIDTH-1:0]      base_reg_q;
  logic [WIDTH:0]        base_sum;
  logic [2*WIDTH-1:0]    fetch_word;
  logic                  run_step, do_push, do_pop;
  logic [ADDR_WIDTH-1:0] lr_top;
  logic                  lr_empty;

  // A stop pulse freezes the datapath for that cycle so the PC is kept.
  assign run_step = (state_q == ST_RUN) && !stop_i;
  assign pc_inc   = pc_q + ADDR_WIDTH'(1);
  assign base_sum = {1'b0, base_reg_q} + {1'b0, base_reg_offset_i};
  assign do_push  = run_step && lr_ld_i && !pc_rst_i;
  assign do_pop   = run_step && !pc_rst_i && pc_ld_i
                    && (jmp_mode_t'(jmp_mode_i) == JMP_RET);

  if_link_stack #(
    .AW   (ADDR_WIDTH),
    .DEPTH(LR_DEPTH)
  ) u_link (
    .clk        (clk),
    .rst        (rst),
    .push_i     (do_push),
    .pop_i      (do_pop),
    .push_data_i(pc_inc),
    .pop_data_o (lr_top),
    .empty_o    (lr_empty),
    .err_o      (lr_err_o)
  );

  // Next-PC selection: reset beats jump beats sequential increment.
  always_comb begin
    pc_d = pc_q;
    if (run_step) begin
      if (pc_rst_i) begin
        pc_d = '0;
      end else if (pc_ld_i) begin
        case (jmp_mode_t'(jmp_mode_i))
          JMP_ABS:  pc_d = ADDR_WIDTH'(jmp_target_i);
          JMP_BASE: pc_d = ADDR_WIDTH'(base_sum);
          JMP_RET:  pc_d = lr_empty ? '0 : lr_top;
          default:  pc_d = pc_q;
        endcase
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // Run/idle FSM with registered load acknowledge; stop wins over start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      load_ack_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          load_ack_q <= load_en_i;
          if (start_i && !stop_i) state_q <= ST_RUN;
        end
        default: begin
          load_ack_q <= 1'b0;
          if (stop_i) state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // PC and base register; a same-cycle base-relative jump sees the old base.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= '0;
      base_reg_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (run_step && base_reg_ld_i) base_reg_q <= base_reg_data_i;
    end
  end

  // Program memory write port, usable only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && load_en_i) mem_q[load_addr_i] <= load_data_i;
  end

  // Combinational fetch; idle presents a NOP to the decoder.
  always_comb begin
    fetch_word = mem_q[pc_q];
    if (state_q == ST_RUN) begin
      instr_o = fetch_word[2*WIDTH-1:WIDTH];
      arg_o   = fetch_word[WIDTH-1:0];
    end else begin
      instr_o = WIDTH'(NOP_OP);
      arg_o   = WIDTH'(NOP_ARG);
    end
  end

  assign pc_o       = pc_q;
  assign running_o  = (state_q == ST_RUN);
  assign load_ack_o = load_ack_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_if_unit.sv
// Bench for if_unit: directed scenarios followed by random control traffic,
// compared cycle by cycle against a queue/array reference model.
module tb_if_unit;
  import if_unit_pkg::*;

  localparam int LRD = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start, stop, load_en, load_ack;
  logic [7:0]  load_addr;
  logic [15:0] load_data;
  logic        pc_rst, pc_ld, base_reg_ld, lr_ld;
  logic [1:0]  jmp_mode;
  logic [7:0]  jmp_target, base_reg_data, base_reg_offset;
  logic [7:0]  instr, arg, pc;
  logic        running, lr_err;
  state_t      state_dbg;

  if_unit #(.WIDTH(8), .ADDR_WIDTH(8), .LR_DEPTH(LRD)) dut (
    .clk(clk), .rst(rst), .start_i(start), .stop_i(stop),
    .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data),
    .load_ack_o(load_ack), .pc_rst_i(pc_rst), .pc_ld_i(pc_ld),
    .jmp_mode_i(jmp_mode), .jmp_target_i(jmp_target),
    .base_reg_ld_i(base_reg_ld), .base_reg_data_i(base_reg_data),
    .base_reg_offset_i(base_reg_offset), .lr_ld_i(lr_ld),
    .instr_o(instr), .arg_o(arg), .pc_o(pc), .running_o(running),
    .lr_err_o(lr_err), .state_o(state_dbg)
  );

  // scoreboard: {running, lr_err, load_ack, pc, instr, arg}
  logic [26:0] exp_q[$];
  int    errors = 0;
  int    checks = 0;
  string phase  = "reset";

  // reference model state
  logic [15:0] m_mem [256];
  bit          m_run, m_err, m_ack;
  logic [7:0]  m_pc, m_base;
`ifdef IF_LR_STACK_EN
  logic [7:0]  m_stk[$];
`else
  logic [7:0]  m_lr;
  bit          m_lr_valid;
`endif

  function automatic logic [26:0] m_obs();
    logic [15:0] w;
    w = m_run ? m_mem[m_pc] : 16'h0000;
    return {m_run, m_err, m_ack, m_pc, w};
  endfunction

  // Apply one clock edge of the architectural rules to the model.
  task automatic model_edge();
    bit         was_run;
    logic [7:0] nxt, ret_a;
    was_run = m_run;
    if (rst) begin
      m_run = 0; m_err = 0; m_ack = 0; m_pc = 8'h00; m_base = 8'h00;
`ifdef IF_LR_STACK_EN
      m_stk.delete();
`else
      m_lr = 8'h00; m_lr_valid = 0;
`endif
      return;
    end
    m_ack = !was_run && load_en;
    if (!was_run) begin
      if (load_en) m_mem[load_addr] = load_data;
      if (start && !stop) m_run = 1;
    end else if (stop) begin
      m_run = 0;
    end else begin
      ret_a = 8'((int'(m_pc) + 1) % 256);
      if (pc_rst) nxt = 8'h00;
      else if (pc_ld) begin
        case (jmp_mode)
          2'b00: nxt = jmp_target;
          2'b01: nxt = 8'((int'(m_base) + int'(base_reg_offset)) % 256);
          2'b10: begin
`ifdef IF_LR_STACK_EN
            if (m_stk.size() == 0) begin nxt = 8'h00; m_err = 1; end
            else nxt = m_stk.pop_back();
`else
            if (!m_lr_valid) begin nxt = 8'h00; m_err = 1; end
            else nxt = m_lr;
`endif
          end
          default: nxt = m_pc;
        endcase
      end else nxt = ret_a;
      if (lr_ld && !pc_rst) begin
`ifdef IF_LR_STACK_EN
        if (m_stk.size() == LRD) begin void'(m_stk.pop_front()); m_err = 1; end
        m_stk.push_back(ret_a);
`else
        m_lr = ret_a; m_lr_valid = 1;
`endif
      end
      if (base_reg_ld) m_base = base_reg_data;
      m_pc = nxt;
    end
  endtask

  // driver tasks
  task automatic clr_in();
    start = 0; stop = 0; load_en = 0; load_addr = 0; load_data = 0;
    pc_rst = 0; pc_ld = 0; jmp_mode = 0; jmp_target = 0;
    base_reg_ld = 0; base_reg_data = 0; base_reg_offset = 0; lr_ld = 0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    exp_q.push_back(m_obs());
    clr_in();
  endtask

  task automatic do_rst();
    @(negedge clk);
    #1;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic load_word(input logic [7:0] a, input logic [15:0] d);
    load_en = 1; load_addr = a; load_data = d; tick();
  endtask

  task automatic jump(input logic [1:0] mode, input logic [7:0] t);
    pc_ld = 1; jmp_mode = mode; jmp_target = t; tick();
  endtask

  task automatic call(input logic [7:0] t);
    lr_ld = 1; jump(2'b00, t);
  endtask

  // monitor: one observation per cycle, sampled on the falling edge
  always @(negedge clk) begin
    logic [26:0] e, g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {running, lr_err, load_ack, pc, instr, arg};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL obs[%s] t=%0t got run=%0b err=%0b ack=%0b pc=%02h ir=%02h arg=%02h want run=%0b err=%0b ack=%0b pc=%02h ir=%02h arg=%02h",
                 phase, $time, g[26], g[25], g[24], g[23:16], g[15:8], g[7:0],
                 e[26], e[25], e[24], e[23:16], e[15:8], e[7:0]);
      end
    end
  end

  // stimulus
  initial begin
    clr_in();
    rst = 1;
    tick();
    rst = 0;

    phase = "load";
    for (int i = 0; i < 256; i++) load_word(8'(i), 16'($urandom));
    load_word(8'h00, 16'h0109);
    load_word(8'h01, 16'h0206);
    load_word(8'h02, 16'h032B);
    load_word(8'h03, 16'h0000);
    tick();

    phase = "fetch";
    start = 1; tick();                  // pc 0 : 01/09
    load_en = 1; load_addr = 8'h2B; load_data = 16'hDEAD;
    tick();                             // pc 1 : 02/06, load ignored
    tick();                             // pc 2 : JMP 2B
    jump(2'b00, 8'h2B);

    phase = "stop";
    start = 1; stop = 1; tick();        // stop wins, pc kept
    start = 1; stop = 1; tick();        // both in idle: stay idle
    start = 1; tick();

    phase = "wrap";
    jump(2'b00, 8'hFE);
    repeat (256) tick();

    phase = "base";
    base_reg_ld = 1; base_reg_data = 8'hA1; tick();
    base_reg_offset = 8'h0C; jump(2'b01, 8'h00);          // AD
    base_reg_ld = 1; base_reg_data = 8'h55;
    base_reg_offset = 8'h0C; jump(2'b01, 8'h00);          // old base: AD
    base_reg_offset = 8'hB0; jump(2'b01, 8'h00);          // 55+B0 wraps to 05
    jump(2'b11, 8'h00);                                   // hold

    phase = "prio";
    pc_rst = 1; lr_ld = 1; jump(2'b00, 8'h77);            // pc 0, no push
    tick();

    phase = "call";
    jump(2'b00, 8'h10);
    call(8'h06);
    tick();
    jump(2'b10, 8'h00);                                   // back to 11
    jump(2'b10, 8'h00);

    phase = "nest";
    for (int k = 0; k < 5; k++) begin
      jump(2'b00, 8'(8'h30 + 8 * k));
      call(8'h80);
    end
    for (int k = 0; k < 5; k++) jump(2'b10, 8'h00);

    phase = "rstmid";
    jump(2'b00, 8'h20);
    do_rst();
    start = 1; tick();                                    // mem[0] again
    tick();
    jump(2'b10, 8'h00);                                   // return before push

    phase = "random";
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_rst();
      end else begin
        start           = ($urandom_range(0, 7) == 0);
        stop            = ($urandom_range(0, 29) == 0);
        load_en         = ($urandom_range(0, 3) == 0);
        load_addr       = 8'($urandom);
        load_data       = 16'($urandom);
        pc_rst          = ($urandom_range(0, 19) == 0);
        pc_ld           = ($urandom_range(0, 2) == 0);
        jmp_mode        = 2'($urandom_range(0, 3));
        jmp_target      = 8'($urandom);
        base_reg_ld     = ($urandom_range(0, 5) == 0);
        base_reg_data   = 8'($urandom);
        base_reg_offset = 8'($urandom);
        lr_ld           = ($urandom_range(0, 5) == 0);
        if (pc_ld && jmp_mode == 2'b10) lr_ld = 0;
        tick();
      end
    end

    phase = "drain";
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog got timeout want completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
